// File: rtl/qspi_mem_ctrl_pkg.sv
// Shared definitions for the QSPI memory controller.
// Holds the RAM command bytes, the flash continuous-read mode nibble, the
// header length, the FSM state encoding and the address decode bit positions.
package qspi_mem_ctrl_pkg;

    localparam logic [7:0] CMD_READ       = 8'h0B;
    localparam logic [7:0] CMD_WRITE      = 8'h02;
    localparam logic [3:0] MODE_NIBBLE    = 4'hA;
    localparam logic [4:0] HEADER_NIBBLES = 5'd8;

    // addr[24] selects RAM space; addr[23] picks RAM B over RAM A
    localparam int ADDR_RAM_BIT  = 24;
    localparam int ADDR_BANK_BIT = 23;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_DUMMY,
        ST_DATA,
        ST_CS_GAP
    } state_t;

    // Bytes go out in address order, so byte 0 must sit in the top of the
    // shift register to be emitted first.
    function automatic logic [31:0] wire_order(input logic [31:0] d);
        return {d[7:0], d[15:8], d[23:16], d[31:24]};
    endfunction

endpackage

// File: rtl/qspi_nibble_shifter.sv
// 32-bit nibble shift register shared by the transmit and receive paths.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   load, load_value    parallel load (header word or write data in wire order)
//   shift, nibble_in    shift left one nibble, capturing nibble_in at the bottom
//   len                 transfer length in bytes-1, used to align read data
//   nibble_out          nibble currently presented to the pads
//   read_data           received bytes in little-endian lanes, unused lanes 0
module qspi_nibble_shifter
    import qspi_mem_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] load_value,
    input  logic        shift,
    input  logic [3:0]  nibble_in,
    input  logic [1:0]  len,
    output logic [3:0]  nibble_out,
    output logic [31:0] read_data
);

    logic [31:0] shift_reg;
    logic [7:0]  sh_byte [WORD_BYTES];

    // Transmit and receive share one shift: the top nibble leaves while the
    // pad nibble enters at the bottom. Only the last 2*(len+1) captures
    // matter, and they occupy the low bytes.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
        end else if (load) begin
            shift_reg <= load_value;
        end else if (shift) begin
            shift_reg <= {shift_reg[27:0], nibble_in};
        end
    end

    assign nibble_out = shift_reg[31:28];

    // The first received byte is the most significant of the captured bytes,
    // so lane gi takes byte (len - gi) of the register.
    genvar gi;
    generate
        for (gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
            assign sh_byte[gi] = shift_reg[8*gi +: 8];
            assign read_data[8*gi +: 8] = (2'(gi) <= len) ? sh_byte[len - 2'(gi)] : 8'h00;
        end
    endgenerate

endmodule

// File: rtl/qspi_mem_ctrl.sv
// Quad-SPI memory controller: one flash (continuous quad read) and two PSRAMs
// (quad 0x0B read, 0x02 write) on a shared SCK and 4-bit bus.
// Ports:
//   clk, rst                     system clock, synchronous active-high reset
//   addr_in, data_in, data_len   request address, write data, bytes-1
//   start_read, start_write      one-cycle request strobes (write wins)
//   busy                         transaction in progress
//   data_out, data_ready         little-endian read data and its valid pulse
//   spi_data_in/out/oe           quad IO from pads, to pads, output enables
//   spi_clk_out                  SCK at clk/2, low when idle
//   spi_*_select                 active-low chip selects
module qspi_mem_ctrl
    import qspi_mem_ctrl_pkg::*;
#(
    parameter int DATA_NIBBLE_START = 14,
    parameter int CS_HIGH_CYCLES    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [24:0] addr_in,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_len,
    input  logic        start_read,
    input  logic        start_write,
    output logic        busy,
    output logic [31:0] data_out,
    output logic        data_ready,
    input  logic [3:0]  spi_data_in,
    output logic [3:0]  spi_data_out,
    output logic [3:0]  spi_data_oe,
    output logic        spi_clk_out,
    output logic        spi_flash_select,
    output logic        spi_ram_a_select,
    output logic        spi_ram_b_select
);

    localparam logic [4:0] DATA_START  = 5'(DATA_NIBBLE_START);
    localparam logic [4:0] DUMMY_LAST  = 5'(DATA_NIBBLE_START - 1);
    localparam logic [4:0] WRITE_START = HEADER_NIBBLES + 5'd1;
    localparam int         GAP_W       = (CS_HIGH_CYCLES > 1) ? $clog2(CS_HIGH_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_HIGH_CYCLES - 1);

    state_t             state_reg, state_next;
    logic [4:0]         nib_reg, nib_next;          // 1-based index of current nibble
    logic               sck_reg, sck_next;
    logic               done_reg, done_next;        // final falling edge has passed
    logic               write_reg, write_next;
    logic [1:0]         len_reg, len_next;
    logic [31:0]        wdata_reg, wdata_next;
    logic [2:0]         sel_n_reg, sel_n_next;      // {flash, ram_a, ram_b}
    logic [3:0]         oe_reg, oe_next;
    logic [31:0]        data_out_reg, data_out_next;
    logic               data_ready_reg, data_ready_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;

    logic               sh_load, sh_shift;
    logic [31:0]        sh_load_value;
    logic [3:0]         sh_nibble;
    logic [31:0]        sh_read_data;

    logic               is_ram, accept;
    logic [31:0]        header_word;
    logic [2:0]         sel_n_decode;
    logic [4:0]         data_last;

    qspi_nibble_shifter u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (sh_load),
        .load_value (sh_load_value),
        .shift      (sh_shift),
        .nibble_in  (spi_data_in),
        .len        (len_reg),
        .nibble_out (sh_nibble),
        .read_data  (sh_read_data)
    );

    // Request decode. A flash write is never accepted, and when both strobes
    // are present the write is what gets decided on.
    assign is_ram       = addr_in[ADDR_RAM_BIT];
    assign accept       = (state_reg == ST_IDLE) && (start_write ? is_ram : start_read);
    assign header_word  = is_ram ? {(start_write ? CMD_WRITE : CMD_READ), 1'b0, addr_in[22:0]}
                                 : {addr_in[23:0], MODE_NIBBLE, 4'h0};
    assign sel_n_decode = !is_ram ? 3'b011 : (addr_in[ADDR_BANK_BIT] ? 3'b110 : 3'b101);

    // Data phase spans 2*(len+1) nibbles, so the last one is first + 2*len + 1.
    assign data_last = (write_reg ? WRITE_START : DATA_START) + {2'b00, len_reg, 1'b1};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            nib_reg        <= '0;
            sck_reg        <= 1'b0;
            done_reg       <= 1'b0;
            write_reg      <= 1'b0;
            len_reg        <= '0;
            wdata_reg      <= '0;
            sel_n_reg      <= 3'b111;
            oe_reg         <= '0;
            data_out_reg   <= '0;
            data_ready_reg <= 1'b0;
            gap_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            nib_reg        <= nib_next;
            sck_reg        <= sck_next;
            done_reg       <= done_next;
            write_reg      <= write_next;
            len_reg        <= len_next;
            wdata_reg      <= wdata_next;
            sel_n_reg      <= sel_n_next;
            oe_reg         <= oe_next;
            data_out_reg   <= data_out_next;
            data_ready_reg <= data_ready_next;
            gap_reg        <= gap_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        nib_next        = nib_reg;
        sck_next        = sck_reg;
        done_next       = done_reg;
        write_next      = write_reg;
        len_next        = len_reg;
        wdata_next      = wdata_reg;
        sel_n_next      = sel_n_reg;
        oe_next         = oe_reg;
        data_out_next   = data_out_reg;
        data_ready_next = 1'b0;
        gap_next        = gap_reg;
        sh_load         = 1'b0;
        sh_shift        = 1'b0;
        sh_load_value   = header_word;

        case (state_reg)
            ST_IDLE: begin
                sck_next   = 1'b0;
                oe_next    = 4'h0;
                sel_n_next = 3'b111;
                gap_next   = '0;
                if (accept) begin
                    // Nibble 1 is on the bus as the select falls; SCK rises next cycle.
                    write_next = start_write;
                    len_next   = data_len;
                    wdata_next = wire_order(data_in);
                    sel_n_next = sel_n_decode;
                    oe_next    = 4'hF;
                    nib_next   = 5'd1;
                    done_next  = 1'b0;
                    sh_load    = 1'b1;
                    state_next = ST_HEADER;
                end
            end

            ST_HEADER, ST_DUMMY, ST_DATA: begin
                if (done_reg) begin
                    // One low-SCK cycle after the last fall, then release the select.
                    state_next = ST_CS_GAP;
                    sel_n_next = 3'b111;
                    oe_next    = 4'h0;
                    done_next  = 1'b0;
                    gap_next   = '0;
                    if (!write_reg) begin
                        data_out_next   = sh_read_data;
                        data_ready_next = 1'b1;
                    end
                end else if (!sck_reg) begin
                    sck_next = 1'b1;
                end else begin
                    // Falling SCK: capture the nibble of the rise just seen and
                    // present the next outgoing nibble.
                    sck_next = 1'b0;
                    sh_shift = 1'b1;
                    nib_next = nib_reg + 5'd1;
                    case (state_reg)
                        ST_HEADER: begin
                            if (nib_reg == HEADER_NIBBLES) begin
                                if (write_reg) begin
                                    sh_shift      = 1'b0;
                                    sh_load       = 1'b1;
                                    sh_load_value = wdata_reg;
                                    state_next    = ST_DATA;
                                end else begin
                                    oe_next    = 4'h0;
                                    state_next = (DATA_START > WRITE_START) ? ST_DUMMY : ST_DATA;
                                end
                            end
                        end
                        ST_DUMMY: begin
                            if (nib_reg == DUMMY_LAST) begin
                                state_next = ST_DATA;
                            end
                        end
                        ST_DATA: begin
                            if (nib_reg == data_last) begin
                                done_next = 1'b1;
                                nib_next  = nib_reg;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end

            ST_CS_GAP: begin
                sck_next   = 1'b0;
                sel_n_next = 3'b111;
                oe_next    = 4'h0;
                if (gap_reg == GAP_LAST) begin
                    gap_next   = '0;
                    state_next = ST_IDLE;
                end else begin
                    gap_next = gap_reg + 1'b1;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy             = (state_reg != ST_IDLE);
    assign data_out         = data_out_reg;
    assign data_ready       = data_ready_reg;
    assign spi_data_out     = sh_nibble & oe_reg;   // keep pads quiet when not driving
    assign spi_data_oe      = oe_reg;
    assign spi_clk_out      = sck_reg;
    assign spi_flash_select = sel_n_reg[2];
    assign spi_ram_a_select = sel_n_reg[1];
    assign spi_ram_b_select = sel_n_reg[0];

endmodule

// File: tb/tb_qspi_mem_ctrl.sv
// Self-checking bench for qspi_mem_ctrl with a behavioural flash + 2 PSRAM model.
module tb_qspi_mem_ctrl;

    localparam int DNS = 14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [24:0] addr_in = '0;
    logic [31:0] data_in = '0;
    logic [1:0]  data_len = '0;
    logic        start_read = 1'b0;
    logic        start_write = 1'b0;
    logic        busy;
    logic [31:0] data_out;
    logic        data_ready;
    logic [3:0]  spi_data_in = '0;
    logic [3:0]  spi_data_out;
    logic [3:0]  spi_data_oe;
    logic        spi_clk_out;
    logic        spi_flash_select, spi_ram_a_select, spi_ram_b_select;

    always #5 clk = ~clk;

    qspi_mem_ctrl #(.DATA_NIBBLE_START(DNS), .CS_HIGH_CYCLES(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .addr_in          (addr_in),
        .data_in          (data_in),
        .data_len         (data_len),
        .start_read       (start_read),
        .start_write      (start_write),
        .busy             (busy),
        .data_out         (data_out),
        .data_ready       (data_ready),
        .spi_data_in      (spi_data_in),
        .spi_data_out     (spi_data_out),
        .spi_data_oe      (spi_data_oe),
        .spi_clk_out      (spi_clk_out),
        .spi_flash_select (spi_flash_select),
        .spi_ram_a_select (spi_ram_a_select),
        .spi_ram_b_select (spi_ram_b_select)
    );

    // ---------------- bookkeeping ----------------
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int t_start = 0, ready_cyc = 0, desel_cyc = 0, idle_cyc = 0;
    int txn_id = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_val;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [7:0]  flash_mem [256];
    logic [7:0]  ram_a [256];
    logic [7:0]  ram_b [256];
    int          cur = 0;
    int          rise_cnt = 0;
    int          n_sel_f = 0, n_sel_a = 0, n_sel_b = 0;
    logic [31:0] hdr = '0, last_hdr = '0;
    logic [3:0]  hi_nib = '0;
    logic        hdr_oe_bad = 1'b0, multi_sel = 1'b0;
    int          nxt, off;
    logic [7:0]  m_addr, m_byte;
    wire         any_sel = !(spi_flash_select && spi_ram_a_select && spi_ram_b_select);
    wire [2:0]   sels = {spi_flash_select, spi_ram_a_select, spi_ram_b_select};
    logic [2:0]  sel_prev = 3'b111;

    always @(negedge spi_flash_select) begin cur = 0; rise_cnt = 0; n_sel_f++; end
    always @(negedge spi_ram_a_select) begin cur = 1; rise_cnt = 0; n_sel_a++; end
    always @(negedge spi_ram_b_select) begin cur = 2; rise_cnt = 0; n_sel_b++; end

    always @(posedge spi_clk_out) begin
        if (any_sel) begin
            rise_cnt++;
            if (rise_cnt <= 8) begin
                hdr = {hdr[27:0], spi_data_out};
                if (spi_data_oe != 4'hF) hdr_oe_bad = 1'b1;
            end
            if (rise_cnt == 8) last_hdr = hdr;
            if (rise_cnt >= 9 && cur != 0 && hdr[31:24] == 8'h02) begin
                if (rise_cnt % 2 == 1) begin
                    hi_nib = spi_data_out;
                end else begin
                    m_addr = hdr[7:0] + 8'((rise_cnt - 10) / 2);
                    if (cur == 1) ram_a[m_addr] = {hi_nib, spi_data_out};
                    else          ram_b[m_addr] = {hi_nib, spi_data_out};
                end
            end
        end
    end

    // Memory updates IO shortly after SCK falls, presenting the nibble for the next rise.
    always @(negedge spi_clk_out) begin
        #1;
        if (any_sel && rise_cnt >= 8) begin
            nxt = rise_cnt + 1;
            if (nxt >= DNS && (cur == 0 || hdr[31:24] == 8'h0B)) begin
                off    = nxt - DNS;
                m_addr = ((cur == 0) ? hdr[15:8] : hdr[7:0]) + 8'(off / 2);
                m_byte = (cur == 0) ? flash_mem[m_addr] : ((cur == 1) ? ram_a[m_addr] : ram_b[m_addr]);
                spi_data_in = (off % 2 == 0) ? m_byte[7:4] : m_byte[3:0];
            end
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    always @(posedge clk) begin
        #1;
        if (data_ready) begin
            ready_cyc = cyc;
            check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                exp_val = exp_q.pop_front();
                check("read_data", data_out, exp_val);
            end
        end
        for (int i = 0; i < 3; i++) begin
            if (!sel_prev[i] && sels[i]) desel_cyc = cyc;
        end
        if ($countones(~sels) > 1) multi_sel = 1'b1;
        sel_prev = sels;
    end

    // ---------------- stimulus helpers ----------------
    task automatic issue(input bit rd, input bit wr, input logic [24:0] a,
                         input logic [31:0] d, input logic [1:0] l);
        @(posedge clk); #1;
        start_read = rd; start_write = wr; addr_in = a; data_in = d; data_len = l;
        @(posedge clk); #1;
        t_start = cyc;
        start_read = 1'b0; start_write = 1'b0;
        txn_id++;
        $display("txn %0d: rd=%0b wr=%0b addr=0x%07h data=0x%08h len=%0d", txn_id, rd, wr, a, d, l);
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
        idle_cyc = cyc;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int f0, a0, b0, k;

    initial begin
        for (int i = 0; i < 256; i++) begin
            flash_mem[i] = 8'h00; ram_a[i] = 8'h00; ram_b[i] = 8'h00;
        end
        flash_mem[8'h10] = 8'h11; flash_mem[8'h11] = 8'h22;
        flash_mem[8'h12] = 8'h33; flash_mem[8'h13] = 8'h44;
        ram_a[8'h21] = 8'h01; ram_a[8'h22] = 8'h02; ram_a[8'h23] = 8'h03;
        ram_b[8'h06] = 8'h66; ram_b[8'h07] = 8'h77;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", 32'({sels, spi_clk_out, busy, data_ready}), 32'h38);
        check("rst_oe", 32'(spi_data_oe), 32'd0);
        check("rst_dout", data_out, 32'd0);
        check("rst_spi_out", 32'(spi_data_out), 32'd0);
        rst = 1'b0;

        // Flash 4-byte read
        exp_q.push_back(32'h44332211);
        issue(1, 0, 25'h0000010, 32'h0, 2'd3);
        wait_idle("flash_rd");
        check("flash_hdr", last_hdr, 32'h000010A0);
        check("flash_ready_lat", 32'(ready_cyc - t_start), 32'd43);
        check("flash_busy_lat", 32'(idle_cyc - t_start), 32'd45);
        check("flash_sel_cnt", 32'(n_sel_f), 32'd1);

        // RAM A 1-byte write, then read back
        issue(0, 1, 25'h1000020, 32'h000000A5, 2'd0);
        wait_idle("ra_wr");
        check("ra_wr_hdr", last_hdr, 32'h02000020);
        check("ra_wr_desel_lat", 32'(desel_cyc - t_start), 32'd21);
        exp_q.push_back(32'h000000A5);
        issue(1, 0, 25'h1000020, 32'h0, 2'd0);
        wait_idle("ra_rd");
        check("ra_rd_hdr", last_hdr, 32'h0B000020);

        // RAM B 2-byte write then 4-byte read; only RAM B select may toggle
        f0 = n_sel_f; a0 = n_sel_a; b0 = n_sel_b;
        issue(0, 1, 25'h1800004, 32'h0000BEEF, 2'd1);
        wait_idle("rb_wr");
        exp_q.push_back(32'h7766BEEF);
        issue(1, 0, 25'h1800004, 32'h0, 2'd3);
        wait_idle("rb_rd");
        check("rb_only_f", 32'(n_sel_f), 32'(f0));
        check("rb_only_a", 32'(n_sel_a), 32'(a0));
        check("rb_only_b", 32'(n_sel_b), 32'(b0 + 2));

        // Requests while busy are ignored
        f0 = n_sel_f; a0 = n_sel_a;
        exp_q.push_back(32'h030201A5);
        issue(1, 0, 25'h1000020, 32'h0, 2'd3);
        repeat (4) @(posedge clk);
        #1;
        start_read = 1'b1; addr_in = 25'h0000010; data_len = 2'd3;
        @(posedge clk); #1;
        start_read = 1'b0; start_write = 1'b1; addr_in = 25'h0000030; data_in = 32'hDEADBEEF;
        @(posedge clk); #1;
        start_write = 1'b0;
        wait_idle("busy_ign");
        check("busy_ign_sel_a", 32'(n_sel_a), 32'(a0 + 1));
        check("busy_ign_sel_f", 32'(n_sel_f), 32'(f0));
        repeat (3) @(posedge clk);
        #1;
        check("busy_ign_held", data_out, 32'h030201A5);

        // Flash write while idle is dropped
        issue(0, 1, 25'h0000010, 32'h12345678, 2'd3);
        check("flash_wr_busy", 32'(busy), 32'd0);
        repeat (5) @(posedge clk);
        #1;
        check("flash_wr_sel", 32'(n_sel_f), 32'(f0));

        // Reset at rise 10 of a read
        issue(1, 0, 25'h1000020, 32'h0, 2'd3);
        k = 0;
        while (rise_cnt != 10 && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        check("rst_mid_reach", 32'(rise_cnt), 32'd10);
        rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ctl", 32'({sels, spi_clk_out, busy, data_ready}), 32'h38);
        check("rst_mid_oe", 32'(spi_data_oe), 32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        exp_q.push_back(32'h00002211);
        issue(1, 0, 25'h0000010, 32'h0, 2'd1);
        wait_idle("post_rst_rd");

        // Simultaneous strobes: write wins
        issue(1, 1, 25'h1000040, 32'h0000005A, 2'd0);
        wait_idle("both_strobes");
        check("both_hdr", last_hdr, 32'h02000040);
        exp_q.push_back(32'h0000005A);
        issue(1, 0, 25'h1000040, 32'h0, 2'd0);
        wait_idle("both_rd");

        repeat (5) @(posedge clk);
        #1;
        check("sb_drain", 32'(exp_q.size()), 32'd0);
        check("single_select", 32'(multi_sel), 32'd0);
        check("hdr_oe", 32'(hdr_oe_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
